// File: rtl/gravity_lock_timer.sv
// Gravity and lock-delay timer for the active piece: level-scaled drop period with
// soft/hard overrides, pause, lock delay while grounded, and a capped number of move-resets.
module gravity_lock_timer #(
    parameter int LEVEL_W     = 4,
    parameter int CNT_W       = 26,
    parameter int BASE_PERIOD = 48000000,
    parameter int LEVEL_STEP  = 5000000,
    parameter int MIN_PERIOD  = 3000000,
    parameter int SOFT_PERIOD = 700000,
    parameter int HARD_PERIOD = 5000,
    parameter int LOCK_DELAY  = 24000000,
    parameter int MAX_RESETS  = 15
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              spawn,
    input  logic [LEVEL_W-1:0]                level,
    input  logic                              soft_drop,
    input  logic                              hard_drop,
    input  logic                              pause,
    input  logic                              grounded,
    input  logic                              moved,
    output logic                              piece_tick,
    output logic                              lock_req,
    output logic [$clog2(MAX_RESETS+1)-1:0]   resets_left
);

    localparam int RL_W = $clog2(MAX_RESETS + 1);
    localparam int PW   = LEVEL_W + CNT_W;

    localparam logic [PW-1:0]    SPAN_C      = PW'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [PW-1:0]    STEP_C      = PW'(LEVEL_STEP);
    localparam logic [CNT_W-1:0] BASE_C      = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] SOFT_C      = CNT_W'(SOFT_PERIOD);
    localparam logic [CNT_W-1:0] HARD_C      = CNT_W'(HARD_PERIOD);
    localparam logic [CNT_W-1:0] LOCK_LAST_C = CNT_W'(LOCK_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [RL_W-1:0]  RL_MAX_C    = RL_W'(MAX_RESETS);
    localparam logic [RL_W-1:0]  RL_ZERO_C   = RL_W'(0);
    localparam logic [RL_W-1:0]  RL_ONE_C    = RL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FALLING  = 2'd1,
        S_GROUNDED = 2'd2,
        S_LOCKED   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_fall_cnt;
    logic [CNT_W-1:0] w_fall_nxt;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_lock_nxt;
    logic [RL_W-1:0]  r_resets_left;
    logic [RL_W-1:0]  w_resets_nxt;
    logic             r_piece_tick;
    logic             w_tick_nxt;
    logic             r_lock_req;
    logic             w_lock_req_nxt;

    logic [PW-1:0]    w_drop;
    logic [CNT_W-1:0] w_grav;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_period_last;

    // Effective drop period; the level product is widened so it cannot wrap.
    always_comb begin
        w_drop = PW'(level) * STEP_C;
        if (w_drop >= SPAN_C) begin
            w_grav = MIN_C;
        end else begin
            w_grav = BASE_C - w_drop[CNT_W-1:0];
        end
        if (hard_drop) begin
            w_period = HARD_C;
        end else if (soft_drop) begin
            w_period = SOFT_C;
        end else begin
            w_period = w_grav;
        end
        w_period_last = w_period - CNT_ONE_C;
    end

    // Next-state, counter and pulse decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_fall_nxt     = r_fall_cnt;
        w_lock_nxt     = r_lock_cnt;
        w_resets_nxt   = r_resets_left;
        w_tick_nxt     = 1'b0;
        w_lock_req_nxt = 1'b0;
        if (spawn) begin
            w_state_nxt  = S_FALLING;
            w_fall_nxt   = CNT_ZERO_C;
            w_lock_nxt   = CNT_ZERO_C;
            w_resets_nxt = RL_MAX_C;
        end else if (pause) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                S_FALLING: begin
                    // ">=" lets a shortened period fire immediately.
                    if (grounded) begin
                        w_state_nxt = S_GROUNDED;
                        w_fall_nxt  = CNT_ZERO_C;
                    end else if (r_fall_cnt >= w_period_last) begin
                        w_tick_nxt = 1'b1;
                        w_fall_nxt = CNT_ZERO_C;
                    end else begin
                        w_fall_nxt = r_fall_cnt + CNT_ONE_C;
                    end
                end
                S_GROUNDED: begin
                    w_fall_nxt = CNT_ZERO_C;
                    if (hard_drop) begin
                        w_lock_req_nxt = 1'b1;
                        w_state_nxt    = S_LOCKED;
                    end else if (!grounded) begin
                        w_state_nxt = S_FALLING;
                        w_lock_nxt  = CNT_ZERO_C;
                    end else if (moved && (r_resets_left != RL_ZERO_C)) begin
                        w_lock_nxt   = CNT_ZERO_C;
                        w_resets_nxt = r_resets_left - RL_ONE_C;
                    end else if (r_lock_cnt >= LOCK_LAST_C) begin
                        w_lock_req_nxt = 1'b1;
                        w_state_nxt    = S_LOCKED;
                    end else begin
                        w_lock_nxt = r_lock_cnt + CNT_ONE_C;
                    end
                end
                S_IDLE, S_LOCKED: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, reset budget and registered output pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fall_cnt    <= CNT_ZERO_C;
            r_lock_cnt    <= CNT_ZERO_C;
            r_resets_left <= RL_MAX_C;
            r_piece_tick  <= 1'b0;
            r_lock_req    <= 1'b0;
        end else begin
            r_fall_cnt    <= w_fall_nxt;
            r_lock_cnt    <= w_lock_nxt;
            r_resets_left <= w_resets_nxt;
            r_piece_tick  <= w_tick_nxt;
            r_lock_req    <= w_lock_req_nxt;
        end
    end

    assign piece_tick  = r_piece_tick;
    assign lock_req    = r_lock_req;
    assign resets_left = r_resets_left;

endmodule

// File: tb/tb_gravity_lock_timer.sv
// Scoreboard bench: a reference model predicts tick/lock pulses with their cycle numbers,
// a monitor pops them when the DUT pulses and also tracks resets_left every cycle.
module tb_gravity_lock_timer;

    localparam int BASE = 100;
    localparam int STEP = 10;
    localparam int MINP = 20;
    localparam int SOFT = 5;
    localparam int HARD = 1;
    localparam int LOCK = 30;
    localparam int MAXR = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       spawn = 1'b0;
    logic [3:0] level = 4'd0;
    logic       soft_drop = 1'b0;
    logic       hard_drop = 1'b0;
    logic       pause = 1'b0;
    logic       grounded = 1'b0;
    logic       moved = 1'b0;
    logic       piece_tick;
    logic       lock_req;
    logic [1:0] resets_left;

    gravity_lock_timer #(
        .LEVEL_W(4), .CNT_W(16), .BASE_PERIOD(BASE), .LEVEL_STEP(STEP), .MIN_PERIOD(MINP),
        .SOFT_PERIOD(SOFT), .HARD_PERIOD(HARD), .LOCK_DELAY(LOCK), .MAX_RESETS(MAXR)
    ) dut (
        .CLK(CLK), .RESET(RESET), .spawn(spawn), .level(level), .soft_drop(soft_drop),
        .hard_drop(hard_drop), .pause(pause), .grounded(grounded), .moved(moved),
        .piece_tick(piece_tick), .lock_req(lock_req), .resets_left(resets_left)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int kind;   // 0 = piece_tick, 1 = lock_req
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  edge_n = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  done = 1'b0;

    // Reference model: phase 0 idle, 1 falling, 2 grounded, 3 locked.
    int m_phase = 0;
    int m_fall = 0;
    int m_lock = 0;
    int m_left = MAXR;

    function automatic int period_now();
        int g;
        g = BASE - int'(level) * STEP;
        if (g < MINP) g = MINP;
        if (hard_drop) return HARD;
        if (soft_drop) return SOFT;
        return g;
    endfunction

    task automatic expect_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = edge_n;
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        if (RESET) begin
            m_phase = 0; m_fall = 0; m_lock = 0; m_left = MAXR;
        end else if (spawn) begin
            m_phase = 1; m_fall = 0; m_lock = 0; m_left = MAXR;
        end else if (!pause) begin
            if (m_phase == 1) begin
                if (grounded) begin
                    m_phase = 2; m_fall = 0;
                end else if (m_fall + 1 >= period_now()) begin
                    expect_ev(0); m_fall = 0;
                end else begin
                    m_fall++;
                end
            end else if (m_phase == 2) begin
                if (hard_drop) begin
                    expect_ev(1); m_phase = 3;
                end else if (!grounded) begin
                    m_phase = 1; m_lock = 0;
                end else if (moved && m_left > 0) begin
                    m_lock = 0; m_left--;
                end else if (m_lock + 1 >= LOCK) begin
                    expect_ev(1); m_phase = 3;
                end else begin
                    m_lock++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        edge_n++;
        model_step();
        @(negedge CLK);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_spawn();
        spawn = 1'b1;
        step();
        spawn = 1'b0;
    endtask

    task automatic do_move();
        moved = 1'b1;
        step();
        moved = 1'b0;
    endtask

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        run(3);
        RESET = 1'b0;
        run(5);
        // Level 0 then level 9 gravity.
        level = 4'd0; do_spawn(); run(320);
        level = 4'd9; run(100);
        // Soft drop engaged mid-period, then released.
        level = 4'd3; do_spawn(); run(50);
        soft_drop = 1'b1; run(20);
        soft_drop = 1'b0; run(150);
        // Grounded lock delay.
        grounded = 1'b1; do_spawn(); run(60);
        // Move-resets: two honoured, third ignored.
        do_spawn(); run(21);
        do_move(); run(20);
        do_move(); run(20);
        do_move(); run(40);
        grounded = 1'b0;
        // Pause mid-period.
        level = 4'd0; do_spawn(); run(40);
        pause = 1'b1; run(1000);
        pause = 1'b0; run(100);
        // RESET while grounded, then spawn + moved + hard_drop together.
        grounded = 1'b1; do_spawn(); run(10);
        RESET = 1'b1; step(); RESET = 1'b0; run(5);
        spawn = 1'b1; moved = 1'b1; hard_drop = 1'b1; step();
        spawn = 1'b0; moved = 1'b0; hard_drop = 1'b0; run(10);
        hard_drop = 1'b1; step(); hard_drop = 1'b0; run(10);
        // Random soak.
        for (int i = 0; i < 15000; i++) begin
            spawn = ($urandom_range(0, 199) == 0);
            if (spawn) level = 4'($urandom_range(0, 15));
            moved = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 59) == 0) grounded = ~grounded;
            if ($urandom_range(0, 99) == 0) soft_drop = ~soft_drop;
            if ($urandom_range(0, 149) == 0) pause = ~pause;
            hard_drop = ($urandom_range(0, 299) == 0);
            RESET = ($urandom_range(0, 2999) == 0);
            step();
        end
        spawn = 1'b0; moved = 1'b0; hard_drop = 1'b0; RESET = 1'b0; pause = 1'b0;
        run(5);
        done = 1'b1;
    end

    // Monitor: pops expected pulses when the DUT pulses, flags missed ones.
    initial begin
        ev_t e;
        forever begin
            @(negedge CLK);
            if (edge_n > 0) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
                    e = exp_q.pop_front();
                    n_checks++; n_fail++;
                    $display("FAIL missed_pulse: got none, required kind %0d at cycle %0d", e.kind, e.cyc);
                end
                if (piece_tick === 1'b1 || lock_req === 1'b1) begin
                    n_checks++;
                    if (piece_tick === 1'b1 && lock_req === 1'b1) begin
                        n_fail++;
                        $display("FAIL both_pulses: got tick=1 lock=1 at cycle %0d, required at most one", edge_n);
                    end else if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_pulse: got tick=%0b lock=%0b at cycle %0d, required none",
                                 piece_tick, lock_req, edge_n);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != (lock_req === 1'b1 ? 1 : 0) || e.cyc != edge_n) begin
                            n_fail++;
                            $display("FAIL pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                     (lock_req === 1'b1 ? 1 : 0), edge_n, e.kind, e.cyc);
                        end
                    end
                end
                n_checks++;
                if (resets_left !== 2'(m_left)) begin
                    n_fail++;
                    $display("FAIL resets_left: got %0d at cycle %0d, required %0d", resets_left, edge_n, m_left);
                end
            end
            if (done) begin
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL drain: got %0d pending pulses, required 0", exp_q.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
